// File: rtl/fifo_sync_thr_pkg.sv
// Shared buffer definitions: default geometry, almost-empty threshold and a
// clog2 helper reused by the buffer blocks of the neuron-array datapath.
package fifo_sync_thr_pkg;

   localparam int unsigned DATA_W_DEF = 256;
   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned AE_THR_DEF = 2;

   // Ceiling log2 for sizing address/count fields from a depth.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_sync_thr_if.sv
// FIFO bus: write side, read side, threshold/error control and status.
// master: the client driving requests; slave: the FIFO.
interface fifo_sync_thr_if
   import fifo_sync_thr_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic [DATA_W-1:0] din;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W:0]   afull_thr;
   logic              clr_err;
   logic [DATA_W-1:0] dout;
   logic              dout_vld;
   logic              full;
   logic              empty;
   logic              prog_full;
   logic              almost_empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;

   modport master (
      output din, wr_en, rd_en, afull_thr, clr_err,
      input  dout, dout_vld, full, empty, prog_full, almost_empty, level,
             overflow, underflow
   );

   modport slave (
      input  din, wr_en, rd_en, afull_thr, clr_err,
      output dout, dout_vld, full, empty, prog_full, almost_empty, level,
             overflow, underflow
   );

endinterface

// File: rtl/fifo_sync_thr_sdp_ram.sv
// Simple dual-port RAM, one clock, synchronous registered read port.
// Ports: clk; we/waddr/wdata write port; re/raddr read port, rdata updates
// only when re is high. No reset so it maps onto block RAM.
module sdp_ram_1clk #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_sync_thr.sv
// Single-clock FIFO with exact occupancy, run-time prog_full threshold,
// almost-empty flag and sticky overflow/underflow.
// Ports: clk, rst_n (async active-low); bus (slave) carries din/wr_en,
// rd_en/dout/dout_vld, afull_thr, clr_err and all status outputs.
module fifo_sync_thr
   import fifo_sync_thr_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned AE_THR = AE_THR_DEF
) (
   input logic            clk,
   input logic            rst_n,
   fifo_sync_thr_if.slave bus
);

   localparam int unsigned LVL_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_nxt;
   logic              full_q;
   logic              empty_q;
   logic              ae_q;
   logic              ovf_q;
   logic              unf_q;
   logic              vld_q;
   logic              rd_seen_q;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] ram_q;

   // Accept decisions from the flags registered at the start of the cycle.
   always_comb begin
      wr_acc    = bus.wr_en & ~full_q;
      rd_acc    = bus.rd_en & ~empty_q;
      level_nxt = level_q;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level_q + LVL_W'(1);
         2'b01:   level_nxt = level_q - LVL_W'(1);
         default: level_nxt = level_q;
      endcase
   end

   // Pointers, level, flags derived from the next level, sticky errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         vld_q     <= 1'b0;
         rd_seen_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         level_q   <= level_nxt;
         full_q    <= (level_nxt == LVL_W'(DEPTH));
         empty_q   <= (level_nxt == '0);
         ae_q      <= (level_nxt <= LVL_W'(AE_THR));
         // Set has priority over clear when both happen in one cycle.
         ovf_q     <= (ovf_q & ~bus.clr_err) | (bus.wr_en & full_q);
         unf_q     <= (unf_q & ~bus.clr_err) | (bus.rd_en & empty_q);
         vld_q     <= rd_acc;
         if (rd_acc) rd_seen_q <= 1'b1;
      end
   end

   sdp_ram_1clk #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.din),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (ram_q)
   );

   // The RAM read register has no reset; mask it until the first read so
   // dout reads zero out of reset and holds between reads.
   assign bus.dout         = rd_seen_q ? ram_q : '0;
   assign bus.dout_vld     = vld_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_empty = ae_q;
   assign bus.level        = level_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
   // Threshold compare is live so a new afull_thr applies in the same cycle.
   assign bus.prog_full    = (level_q >= bus.afull_thr);

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Randomised self-checking bench for fifo_sync_thr (16-bit x 16-deep)
// against a queue-based reference model.
module tb_fifo_sync_thr;
   import fifo_sync_thr_pkg::*;

   localparam int unsigned DW     = 16;
   localparam int unsigned AW     = 4;
   localparam int          DEPTH  = 16;
   localparam int          AE_LIM = 2;

   logic clk;
   logic rst_n;

   fifo_sync_thr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   fifo_sync_thr #(.DATA_W(DW), .ADDR_W(AW), .AE_THR(AE_LIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] q [$];
   logic [DW-1:0] exp_dout;
   logic          exp_vld;
   logic          exp_ovf;
   logic          exp_unf;
   int            cur_thr;
   int            n_pop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout = '0;
      exp_vld  = 1'b0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
   endtask

   task automatic check_all();
      chk("level",        32'(bus.level),        32'(q.size()));
      chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
      chk("empty",        32'(bus.empty),        32'(q.size() == 0));
      chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE_LIM));
      chk("dout_vld",     32'(bus.dout_vld),     32'(exp_vld));
      chk("dout",         32'(bus.dout),         32'(exp_dout));
      chk("overflow",     32'(bus.overflow),     32'(exp_ovf));
      chk("underflow",    32'(bus.underflow),    32'(exp_unf));
   endtask

   // One clock of stimulus, then update the model and check every output.
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic clr);
      int pre;
      bit wok;
      bit rok;
      @(negedge clk);
      bus.wr_en     = wr;
      bus.rd_en     = rd;
      bus.din       = d;
      bus.clr_err   = clr;
      bus.afull_thr = 5'(cur_thr);
      #1;
      chk("prog_full", 32'(bus.prog_full), 32'(q.size() >= cur_thr));
      @(posedge clk);
      #1;
      pre = q.size();
      wok = wr && (pre < DEPTH);
      rok = rd && (pre > 0);
      if (rok) begin
         exp_dout = q.pop_front();
         n_pop++;
      end
      if (wok) q.push_back(d);
      exp_vld = rok;
      if (clr) begin
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end
      if (wr && pre == DEPTH) exp_ovf = 1'b1;
      if (rd && pre == 0)     exp_unf = 1'b1;
      check_all();
   endtask

   initial begin
      int iter;
      bit w;
      bit r;
      bus.wr_en     = 1'b0;
      bus.rd_en     = 1'b0;
      bus.din       = '0;
      bus.clr_err   = 1'b0;
      cur_thr       = 12;
      bus.afull_thr = 5'(cur_thr);
      n_pop         = 0;
      model_reset();

      // Reset held for three cycles.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("prog_full_rst", 32'(bus.prog_full), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 0..15 back-to-back; prog_full rises at 12, full at 16.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);

      // Write while full is dropped and flagged.
      step(1'b1, 1'b0, 16'h00AA, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);

      // Full with both: read wins, write rejected, overflow stays.
      step(1'b1, 1'b1, 16'h0055, 1'b0);
      step(1'b1, 1'b0, 16'h0100, 1'b0);

      // Clear errors, then drain; retune threshold at level 10.
      step(1'b0, 1'b0, '0, 1'b1);
      iter = 0;
      while (q.size() > 0 && iter < 40) begin
         if (q.size() == 10) cur_thr = 8;
         step(1'b0, 1'b1, '0, 1'b0);
         iter++;
      end
      step(1'b0, 1'b0, '0, 1'b0);

      // Empty read, then empty with both: no fall-through.
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b1, 16'h0777, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);

      // Reach level 5, then 10 cycles of simultaneous traffic.
      while (q.size() < 5) step(1'b1, 1'b0, DW'($urandom), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);

      // Random wrap-around traffic keeping level within 3..14.
      n_pop = 0;
      iter  = 0;
      while (n_pop < 100 && iter < 3000) begin
         w = (q.size() < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
         r = (q.size() > 3)  ? 1'($urandom_range(0, 1)) : 1'b0;
         step(w, r, DW'($urandom), 1'b0);
         iter++;
      end
      chk("wrap_pops", 32'(n_pop >= 100), 32'(1));
      chk("wrap_ovf",  32'(bus.overflow),  32'(0));
      chk("wrap_unf",  32'(bus.underflow), 32'(0));
      step(1'b0, 1'b0, '0, 1'b0);

      // Asynchronous reset mid-stream takes effect without a clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_level", 32'(bus.level),    32'(0));
      chk("async_empty", 32'(bus.empty),    32'(1));
      chk("async_vld",   32'(bus.dout_vld), 32'(0));
      chk("async_dout",  32'(bus.dout),     32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Old contents are gone: a read needs a fresh write.
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b0, 16'hBEEF, 1'b1);
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
